// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ID/EX ALU-control stage:
// ALU control codes, R-type funct values, R-type ALUop and FSM states.
package alu_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef logic [3:0] ctrl_code_t;
    typedef logic [5:0] funct_t;

    localparam ctrl_code_t ALU_AND  = 4'b0000;
    localparam ctrl_code_t ALU_OR   = 4'b0001;
    localparam ctrl_code_t ALU_ADD  = 4'b0010;
    localparam ctrl_code_t ALU_SLL  = 4'b0011;
    localparam ctrl_code_t ALU_SRL  = 4'b0100;
    localparam ctrl_code_t ALU_MULA = 4'b0101;
    localparam ctrl_code_t ALU_SUB  = 4'b0110;
    localparam ctrl_code_t ALU_SLT  = 4'b0111;
    localparam ctrl_code_t ALU_ADDU = 4'b1000;
    localparam ctrl_code_t ALU_SUBU = 4'b1001;
    localparam ctrl_code_t ALU_XOR  = 4'b1010;
    localparam ctrl_code_t ALU_SLTU = 4'b1011;
    localparam ctrl_code_t ALU_NOR  = 4'b1100;
    localparam ctrl_code_t ALU_SRA  = 4'b1101;

    localparam funct_t FN_SLL  = 6'b000000;
    localparam funct_t FN_SRL  = 6'b000010;
    localparam funct_t FN_SRA  = 6'b000011;
    localparam funct_t FN_ADD  = 6'b100000;
    localparam funct_t FN_ADDU = 6'b100001;
    localparam funct_t FN_SUB  = 6'b100010;
    localparam funct_t FN_SUBU = 6'b100011;
    localparam funct_t FN_AND  = 6'b100100;
    localparam funct_t FN_OR   = 6'b100101;
    localparam funct_t FN_XOR  = 6'b100110;
    localparam funct_t FN_NOR  = 6'b100111;
    localparam funct_t FN_SLT  = 6'b101010;
    localparam funct_t FN_SLTU = 6'b101011;
    localparam funct_t FN_MULA = 6'b111000;

    localparam logic [3:0] RTYPE_OP = 4'b1111;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction-side bundle between main control and the ALU-control stage.
// master = upstream driver of the decode inputs, slave = the stage itself.
interface alu_ctrl_if #(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 4
);
    logic              InValid;
    logic [OP_W-1:0]   ALUop;
    logic [FUNC_W-1:0] FuncCode;
    logic              Stall;
    logic              Flush;
    logic [CTRL_W-1:0] ALUCtrl;
    logic              CtrlValid;
    logic              IllegalFunc;
    logic              StallReq;
    logic              MulDone;

    modport master (
        output InValid, ALUop, FuncCode, Stall, Flush,
        input  ALUCtrl, CtrlValid, IllegalFunc, StallReq, MulDone
    );

    modport slave (
        input  InValid, ALUop, FuncCode, Stall, Flush,
        output ALUCtrl, CtrlValid, IllegalFunc, StallReq, MulDone
    );
endinterface

// File: rtl/alu_func_decode.sv
// ALUop / funct to ALU control word decoder with unsupported-funct flag.
// Latency: purely combinational.
// Backpressure: none; stateless.
module alu_func_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 4
) (
    input  logic [OP_W-1:0]   alu_op,
    input  logic [FUNC_W-1:0] func_code,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal
);

    logic       rtype;
    logic       bad_funct;
    ctrl_code_t code;

    assign rtype = &alu_op;

    always_comb begin
        code      = ALU_AND;
        bad_funct = 1'b0;
        unique case (func_code)
            FN_SLL:  code = ALU_SLL;
            FN_SRL:  code = ALU_SRL;
            FN_SRA:  code = ALU_SRA;
            FN_ADD:  code = ALU_ADD;
            FN_ADDU: code = ALU_ADDU;
            FN_SUB:  code = ALU_SUB;
            FN_SUBU: code = ALU_SUBU;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_XOR:  code = ALU_XOR;
            FN_NOR:  code = ALU_NOR;
            FN_SLT:  code = ALU_SLT;
            FN_SLTU: code = ALU_SLTU;
            FN_MULA: code = ALU_MULA;
            default: begin
                code      = ALU_AND;
                bad_funct = 1'b1;
            end
        endcase

        // Non-R-type ops pass straight through; funct is irrelevant there.
        ctrl    = rtype ? CTRL_W'(code) : CTRL_W'(alu_op);
        illegal = rtype & bad_funct;
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU-control pipeline register with multi-cycle MULA sequencing.
// Latency: 1 cycle from accepted inputs to ALUCtrl; MULA occupies MUL_CYCLES cycles.
// Backpressure: holds on Stall; raises StallReq while MULA still has cycles left.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int FUNC_W     = 6,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic     CLK,
    input  logic     Reset_L,
    alu_ctrl_if.slave bus
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              vld;
        logic              illegal;
    } pipe_t;

    pipe_t             pipe_q, pipe_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              stall_req;
    logic              mul_done;
    logic              load;

    alu_func_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .alu_op    (bus.ALUop),
        .func_code (bus.FuncCode),
        .ctrl      (dec_ctrl),
        .illegal   (dec_illegal)
    );

    assign stall_req = (state_q == MUL) && (cnt_q != '0);
    assign mul_done  = (state_q == MUL) && (cnt_q == '0);

    // The final MUL cycle is not a stall, so it may accept the next instruction.
    assign load = !bus.Flush && !bus.Stall && !stall_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pipe_d  = pipe_q;

        if (bus.Flush) begin
            state_d      = IDLE;
            cnt_d        = '0;
            pipe_d.vld   = 1'b0;
            pipe_d.illegal = 1'b0;
        end else begin
            if (state_q == MUL) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end

            if (load) begin
                pipe_d.ctrl    = dec_ctrl;
                pipe_d.vld     = bus.InValid;
                pipe_d.illegal = dec_illegal & bus.InValid;
                if (bus.InValid && (dec_ctrl == CTRL_W'(ALU_MULA))) begin
                    state_d = MUL;
                    cnt_d   = CNT_W'(MUL_CYCLES - 1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pipe_q  <= pipe_d;
        end
    end

    assign bus.ALUCtrl     = pipe_q.ctrl;
    assign bus.CtrlValid   = pipe_q.vld;
    assign bus.IllegalFunc = pipe_q.illegal;
    assign bus.StallReq    = stall_req;
    assign bus.MulDone     = mul_done;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage with MUL_CYCLES=3; expected values are
// hand-computed from the decode table and cycle timing.
module tb_alu_ctrl_stage;
    import alu_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_ctrl_if #(.OP_W(4), .FUNC_W(6), .CTRL_W(4)) bus ();

    alu_ctrl_stage #(
        .OP_W       (4),
        .FUNC_W     (6),
        .CTRL_W     (4),
        .MUL_CYCLES (3)
    ) dut (
        .CLK     (clk),
        .Reset_L (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [3:0] op, input logic [5:0] fn);
        bus.InValid  = vld;
        bus.ALUop    = op;
        bus.FuncCode = fn;
    endtask

    logic [5:0] tbl_fn  [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100001,
                                6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                6'b101010, 6'b101011, 6'b000001};
    logic [3:0] tbl_exp [13] = '{4'h3, 4'h4, 4'hD, 4'h2, 4'h8,
                                4'h9, 4'h0, 4'h1, 4'hA, 4'hC,
                                4'h7, 4'hB, 4'h0};
    logic       tbl_ill [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1};

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        drive(1'b0, 4'h0, 6'h00);

        step();
        step();
        check_eq("rst_ctrl", bus.ALUCtrl, 0);
        check_eq("rst_vld", bus.CtrlValid, 0);
        check_eq("rst_ill", bus.IllegalFunc, 0);
        check_eq("rst_stallreq", bus.StallReq, 0);
        check_eq("rst_muldone", bus.MulDone, 0);
        rst_n = 1'b1;

        // SUB decode
        drive(1'b1, RTYPE_OP, 6'b100010);
        step();
        check_eq("sub_ctrl", bus.ALUCtrl, 4'h6);
        check_eq("sub_vld", bus.CtrlValid, 1);
        check_eq("sub_ill", bus.IllegalFunc, 0);

        // pass-through ignores funct
        drive(1'b1, 4'b0010, 6'b111111);
        step();
        check_eq("pass_ctrl", bus.ALUCtrl, 4'h2);
        check_eq("pass_ill", bus.IllegalFunc, 0);

        drive(1'b1, RTYPE_OP, 6'b111111);
        step();
        check_eq("bad_ctrl", bus.ALUCtrl, 4'h0);
        check_eq("bad_ill", bus.IllegalFunc, 1);

        for (int i = 0; i < 13; i++) begin
            drive(1'b1, RTYPE_OP, tbl_fn[i]);
            step();
            check_eq($sformatf("tbl_ctrl_%0d", i), bus.ALUCtrl, tbl_exp[i]);
            check_eq($sformatf("tbl_ill_%0d", i), bus.IllegalFunc, tbl_ill[i]);
        end

        // invalid instruction: word loads, valid and illegal stay low
        drive(1'b0, RTYPE_OP, 6'b111111);
        step();
        check_eq("inv_vld", bus.CtrlValid, 0);
        check_eq("inv_ill", bus.IllegalFunc, 0);

        // MULA, then ADD waiting on the inputs
        drive(1'b1, RTYPE_OP, 6'b111000);
        step();
        check_eq("mul_c1_ctrl", bus.ALUCtrl, 4'h5);
        check_eq("mul_c1_sr", bus.StallReq, 1);
        check_eq("mul_c1_md", bus.MulDone, 0);
        drive(1'b1, RTYPE_OP, 6'b100000);
        step();
        check_eq("mul_c2_ctrl", bus.ALUCtrl, 4'h5);
        check_eq("mul_c2_sr", bus.StallReq, 1);
        check_eq("mul_c2_md", bus.MulDone, 0);
        step();
        check_eq("mul_c3_ctrl", bus.ALUCtrl, 4'h5);
        check_eq("mul_c3_sr", bus.StallReq, 0);
        check_eq("mul_c3_md", bus.MulDone, 1);
        step();
        check_eq("after_mul_ctrl", bus.ALUCtrl, 4'h2);
        check_eq("after_mul_md", bus.MulDone, 0);
        check_eq("after_mul_sr", bus.StallReq, 0);

        // back-to-back MULA; Stall during the second one does not freeze the count
        drive(1'b1, RTYPE_OP, 6'b111000);
        step();
        step();
        step();
        check_eq("b2b_first_md", bus.MulDone, 1);
        step();
        check_eq("b2b_second_sr", bus.StallReq, 1);
        check_eq("b2b_second_md", bus.MulDone, 0);
        check_eq("b2b_second_ctrl", bus.ALUCtrl, 4'h5);
        bus.Stall = 1'b1;
        drive(1'b1, RTYPE_OP, 6'b100000);
        step();
        check_eq("b2b_stall_sr", bus.StallReq, 1);
        step();
        check_eq("b2b_stall_md", bus.MulDone, 1);
        step();
        check_eq("b2b_idle_ctrl", bus.ALUCtrl, 4'h5);
        check_eq("b2b_idle_md", bus.MulDone, 0);
        check_eq("b2b_idle_sr", bus.StallReq, 0);
        bus.Stall = 1'b0;
        step();
        check_eq("b2b_add_ctrl", bus.ALUCtrl, 4'h2);

        // Stall holds the register while inputs change
        bus.Stall = 1'b1;
        drive(1'b0, RTYPE_OP, 6'b100010);
        step();
        check_eq("stall1_ctrl", bus.ALUCtrl, 4'h2);
        check_eq("stall1_vld", bus.CtrlValid, 1);
        drive(1'b1, RTYPE_OP, 6'b100101);
        step();
        check_eq("stall2_ctrl", bus.ALUCtrl, 4'h2);
        check_eq("stall2_vld", bus.CtrlValid, 1);
        bus.Flush = 1'b1;
        step();
        check_eq("flush_stall_vld", bus.CtrlValid, 0);
        bus.Flush = 1'b0;
        bus.Stall = 1'b0;
        step();
        check_eq("resume_ctrl", bus.ALUCtrl, 4'h1);
        check_eq("resume_vld", bus.CtrlValid, 1);

        // invalid MULA never starts the sequence
        drive(1'b0, RTYPE_OP, 6'b111000);
        step();
        check_eq("inv_mul_ctrl", bus.ALUCtrl, 4'h5);
        check_eq("inv_mul_sr", bus.StallReq, 0);
        step();
        check_eq("inv_mul_md", bus.MulDone, 0);

        // Flush in the first MUL cycle
        drive(1'b1, RTYPE_OP, 6'b111000);
        step();
        check_eq("fmul_c1_sr", bus.StallReq, 1);
        bus.Flush = 1'b1;
        drive(1'b0, 4'h0, 6'h00);
        step();
        check_eq("fmul_sr", bus.StallReq, 0);
        check_eq("fmul_md", bus.MulDone, 0);
        check_eq("fmul_vld", bus.CtrlValid, 0);
        bus.Flush = 1'b0;
        step();
        check_eq("fmul_md_later", bus.MulDone, 0);
        step();
        check_eq("fmul_md_later2", bus.MulDone, 0);

        // async reset mid-MUL, between edges
        drive(1'b1, RTYPE_OP, 6'b111000);
        step();
        check_eq("amul_sr", bus.StallReq, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ctrl", bus.ALUCtrl, 0);
        check_eq("arst_vld", bus.CtrlValid, 0);
        check_eq("arst_ill", bus.IllegalFunc, 0);
        check_eq("arst_sr", bus.StallReq, 0);
        check_eq("arst_md", bus.MulDone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
